ddr_ring_sched: RTL and testbench

DDR_RING_SCHED -- requirements
Module: ddr_ring_sched

---
 rtl/ddr_ring_pkg.sv | 15 +
 rtl/sync_len_fifo.sv | 63 ++++++
 rtl/ddr_ring_sched.sv | 144 ++++++++++++++
 tb/tb_ddr_ring_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_ring_pkg.sv
// Shared definitions for the DDR ring scheduler.
// Contents: beat/page geometry constants and the arbiter state encoding.
package ddr_ring_pkg;

  localparam int BEAT_BYTES      = 64;
  localparam int PAGE_BEATS      = 64;
  localparam int MAX_BURST_BEATS = 24;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sync_len_fifo.sv
// Synchronous FIFO holding granted write-burst lengths until their B responses
// return. Show-ahead read; full/empty are registered.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data, full, empty.
module sync_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + CW'(1);
    else if (do_pop && !do_push) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/ddr_ring_sched.sv
// DDR ring-buffer scheduler: arbitrates write-burst grants (ingress) and
// single-beat read grants (CSR drain) over a ring of 64-byte beats.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_req/wr_beats     write burst request and length (held until granted)
//   wr_gnt/_addr/_beats write grant pulse, AWADDR, granted beats
//   wr_done             B response accepted (in order)
//   rd_en               read enable; rd_gnt/rd_gnt_addr read grant pulse/ARADDR
//   rd_done             R beat consumed
//   used_beats          registered allocated-minus-freed beat count
//   wr_stall_cnt        saturating count of cycles wr_req was blocked by space
//   err_spurious        sticky: completion arrived with nothing outstanding
module ddr_ring_sched
  import ddr_ring_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 31,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RING_AW    = 24,
  parameter int unsigned           MAX_WR_OUT = 4,
  parameter int unsigned           MAX_RD_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [7:0]            wr_beats,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] wr_gnt_addr,
  output logic [7:0]            wr_gnt_beats,
  input  logic                  wr_done,
  input  logic                  rd_en,
  output logic                  rd_gnt,
  output logic [ADDR_WIDTH-1:0] rd_gnt_addr,
  input  logic                  rd_done,
  output logic [RING_AW:0]      used_beats,
  output logic [31:0]           wr_stall_cnt,
  output logic                  err_spurious
);

  localparam int PW = RING_AW + 1;
  localparam logic [PW-1:0] RING_BEATS = {1'b1, {RING_AW{1'b0}}};

  arb_state_e state, state_next;
  logic       rr_wr_last, rr_next;

  logic [PW-1:0] alloc, commit, rd_issue, rd_free;
  logic [PW-1:0] used_now, free_now, rd_out;
  logic [8:0]    page_room;
  logic [7:0]    burst_beats;
  logic          space_ok, wr_ok, rd_ok;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          pop_ok, rd_free_ok, spurious;

  function automatic logic [ADDR_WIDTH-1:0] ring_addr(input logic [RING_AW-1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BEAT_BYTES);
  endfunction

  // Clip the burst at the next 4 KiB page boundary.
  assign page_room   = 9'(PAGE_BEATS) - {3'b000, alloc[5:0]};
  assign burst_beats = ({1'b0, wr_beats} < page_room) ? wr_beats : page_room[7:0];

  assign used_now = alloc - rd_free;
  assign free_now = RING_BEATS - used_now;
  assign space_ok = (32'(free_now) >= 32'(burst_beats));
  assign wr_ok    = wr_req && space_ok && !fifo_full;

  assign rd_out = rd_issue - rd_free;
  assign rd_ok  = rd_en && (rd_issue != commit) && (32'(rd_out) < MAX_RD_OUT);

  assign pop_ok     = wr_done && !fifo_empty;
  assign rd_free_ok = rd_done && (rd_issue != rd_free);
  assign spurious   = (wr_done && fifo_empty) || (rd_done && (rd_issue == rd_free));

  // Round-robin memory only moves on contended decisions, so the first
  // contention after reset always goes to the write side.
  always_comb begin
    state_next = ARB_IDLE;
    rr_next    = rr_wr_last;
    case (state)
      ARB_IDLE: begin
        if (wr_ok && rd_ok) begin
          if (rr_wr_last) begin
            state_next = ARB_RD;
            rr_next    = 1'b0;
          end else begin
            state_next = ARB_WR;
            rr_next    = 1'b1;
          end
        end else if (wr_ok) begin
          state_next = ARB_WR;
        end else if (rd_ok) begin
          state_next = ARB_RD;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign wr_gnt       = (state == ARB_WR);
  assign rd_gnt       = (state == ARB_RD);
  assign wr_gnt_beats = wr_gnt ? burst_beats : 8'd0;
  assign wr_gnt_addr  = wr_gnt ? ring_addr(alloc[RING_AW-1:0]) : '0;
  assign rd_gnt_addr  = rd_gnt ? ring_addr(rd_issue[RING_AW-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      rr_wr_last   <= 1'b0;
      alloc        <= '0;
      commit       <= '0;
      rd_issue     <= '0;
      rd_free      <= '0;
      used_beats   <= '0;
      wr_stall_cnt <= '0;
      err_spurious <= 1'b0;
    end else begin
      state      <= state_next;
      rr_wr_last <= rr_next;
      if (wr_gnt)     alloc    <= alloc + PW'(burst_beats);
      if (pop_ok)     commit   <= commit + PW'(fifo_dout);
      if (rd_gnt)     rd_issue <= rd_issue + PW'(1);
      if (rd_free_ok) rd_free  <= rd_free + PW'(1);
      used_beats <= used_now;
      if (wr_req && !space_ok && (wr_stall_cnt != '1))
        wr_stall_cnt <= wr_stall_cnt + 32'd1;
      if (spurious) err_spurious <= 1'b1;
    end
  end

  sync_len_fifo #(
    .DEPTH (MAX_WR_OUT),
    .WIDTH (8)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_gnt),
    .push_data (burst_beats),
    .pop       (pop_ok),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Directed bench for ddr_ring_sched with a 128-beat ring (RING_AW=7).
module tb_ddr_ring_sched;

  localparam logic [30:0] BASE = 31'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [7:0]  wr_beats;
  logic        wr_gnt;
  logic [30:0] wr_gnt_addr;
  logic [7:0]  wr_gnt_beats;
  logic        wr_done;
  logic        rd_en;
  logic        rd_gnt;
  logic [30:0] rd_gnt_addr;
  logic        rd_done;
  logic [7:0]  used_beats;
  logic [31:0] wr_stall_cnt;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;

  ddr_ring_sched #(
    .ADDR_WIDTH (31),
    .BASE_ADDR  (BASE),
    .RING_AW    (7),
    .MAX_WR_OUT (4),
    .MAX_RD_OUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_beats     (wr_beats),
    .wr_gnt       (wr_gnt),
    .wr_gnt_addr  (wr_gnt_addr),
    .wr_gnt_beats (wr_gnt_beats),
    .wr_done      (wr_done),
    .rd_en        (rd_en),
    .rd_gnt       (rd_gnt),
    .rd_gnt_addr  (rd_gnt_addr),
    .rd_done      (rd_done),
    .used_beats   (used_beats),
    .wr_stall_cnt (wr_stall_cnt),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a burst, expect the grant one cycle later, then release.
  task automatic wr_grant(input string tag, input logic [7:0] beats,
                          input logic [30:0] exp_addr, input logic [7:0] exp_beats);
    wr_req   = 1'b1;
    wr_beats = beats;
    tick();
    check({tag, "_gnt"}, wr_gnt, 1'b1);
    check({tag, "_addr"}, wr_gnt_addr, exp_addr);
    check({tag, "_beats"}, wr_gnt_beats, exp_beats);
    wr_req = 1'b0;
    tick();
  endtask

  task automatic pulse_wr_done(input int n);
    for (int k = 0; k < n; k++) begin
      wr_done = 1'b1;
      tick();
    end
    wr_done = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_req   = 1'b0;
    wr_beats = 8'd0;
    wr_done  = 1'b0;
    rd_en    = 1'b0;
    rd_done  = 1'b0;
    tick();
    tick();
    check("rst_wr_gnt", wr_gnt, 1'b0);
    check("rst_rd_gnt", rd_gnt, 1'b0);
    check("rst_wr_addr", wr_gnt_addr, 31'd0);
    check("rst_wr_beats", wr_gnt_beats, 8'd0);
    check("rst_used", used_beats, 8'd0);
    check("rst_stall", wr_stall_cnt, 32'd0);
    check("rst_err", err_spurious, 1'b0);
    rst = 1'b0;
    tick();

    // First burst at alloc=0.
    wr_grant("w24", 8'd24, BASE, 8'd24);
    tick();
    check("used_24", used_beats, 8'd24);

    // Bring alloc to 50, then a 24-beat request is clipped at the page.
    wr_grant("w26", 8'd26, BASE + 31'd1536, 8'd26);
    wr_grant("w_clip", 8'd24, BASE + 31'd3200, 8'd14);
    wr_grant("w_rem", 8'd10, BASE + 31'd4096, 8'd10);
    tick();
    check("used_74", used_beats, 8'd74);

    // Four writes outstanding: a fifth is held until a B response.
    wr_req   = 1'b1;
    wr_beats = 8'd4;
    tick();
    check("w5_held_a", wr_gnt, 1'b0);
    tick();
    check("w5_held_b", wr_gnt, 1'b0);
    check("w5_no_stall", wr_stall_cnt, 32'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("w5_held_c", wr_gnt, 1'b0);
    tick();
    check("w5_gnt", wr_gnt, 1'b1);
    check("w5_addr", wr_gnt_addr, BASE + 31'd4736);
    check("w5_beats", wr_gnt_beats, 8'd4);
    wr_req = 1'b0;
    tick();

    // Drain all B responses (commit = 78), then contend both sides.
    pulse_wr_done(4);
    wr_req   = 1'b1;
    wr_beats = 8'd1;
    rd_en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("alt_wr_gnt", wr_gnt, 1'b1);
        check("alt_wr_rd0", rd_gnt, 1'b0);
        check("alt_wr_addr", wr_gnt_addr, BASE + 31'((78 + i / 2) * 64));
      end else begin
        check("alt_rd_gnt", rd_gnt, 1'b1);
        check("alt_rd_wr0", wr_gnt, 1'b0);
        check("alt_rd_addr", rd_gnt_addr, BASE + 31'((i / 2) * 64));
      end
      tick();
      check("alt_idle_gap", {wr_gnt, rd_gnt}, 2'b00);
    end
    wr_req = 1'b0;
    rd_en  = 1'b0;

    // Fill the ring to 128 beats with nothing freed.
    pulse_wr_done(4);
    wr_grant("fill_a", 8'd24, BASE + 31'd5248, 8'd24);
    wr_grant("fill_b", 8'd22, BASE + 31'd6784, 8'd22);
    wr_req   = 1'b1;
    wr_beats = 8'd1;
    tick();
    check("full_gnt0", wr_gnt, 1'b0);
    check("full_stall1", wr_stall_cnt, 32'd1);
    tick();
    check("full_stall2", wr_stall_cnt, 32'd2);
    tick();
    check("full_stall3", wr_stall_cnt, 32'd3);
    check("full_used", used_beats, 8'd128);
    wr_req = 1'b0;
    tick();
    check("full_stall_hold", wr_stall_cnt, 32'd3);

    // One freed beat: a 2-beat request still stalls, a 1-beat one goes.
    wr_req   = 1'b1;
    wr_beats = 8'd2;
    rd_done  = 1'b1;
    tick();
    rd_done = 1'b0;
    check("free1_w2_gnt_a", wr_gnt, 1'b0);
    check("free1_stall4", wr_stall_cnt, 32'd4);
    tick();
    check("free1_w2_gnt_b", wr_gnt, 1'b0);
    check("free1_stall5", wr_stall_cnt, 32'd5);
    wr_req = 1'b0;
    tick();
    wr_grant("free1_w1", 8'd1, BASE, 8'd1);
    check("free1_stall_final", wr_stall_cnt, 32'd5);
    check("no_err_yet", err_spurious, 1'b0);

    // Reset with three writes outstanding.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_wr_gnt", wr_gnt, 1'b0);
    check("mid_rst_rd_gnt", rd_gnt, 1'b0);
    check("mid_rst_wr_addr", wr_gnt_addr, 31'd0);
    check("mid_rst_rd_addr", rd_gnt_addr, 31'd0);
    check("mid_rst_beats", wr_gnt_beats, 8'd0);
    check("mid_rst_used", used_beats, 8'd0);
    check("mid_rst_stall", wr_stall_cnt, 32'd0);
    check("mid_rst_err", err_spurious, 1'b0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("spur_err", err_spurious, 1'b1);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_no_rd", rd_gnt, 1'b0);
    end
    rd_en = 1'b0;
    check("spur_used0", used_beats, 8'd0);
    wr_grant("post_rst", 8'd24, BASE, 8'd24);
    check("err_sticky", err_spurious, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
